// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU defaults, sequencer state encoding and condition-code bit positions
package alu_pkg;

    localparam int ALU_WIDTH = 64;
    localparam int ALU_CHUNK = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CC_ZF = 0;
    localparam int CC_SF = 1;
    localparam int CC_OF = 2;

endpackage

// File: rtl/sub_chunk.sv
// sub_chunk: CHUNK-bit combinational adder slice
//   x, y  in   CHUNK  addends
//   cin   in   1      carry in
//   sum   out  CHUNK  x + y + cin, modulo 2^CHUNK
//   cout  out  1      carry out
module sub_chunk #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/sub64_seq.sv
// sub64_seq: multi-cycle signed subtractor (out = a - b) with Y86 ZF/SF/OF, one slice per cycle
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   operand handshake (a, b sampled at accept)
//   a, b                 signed minuend / subtrahend
//   out_valid, out_ready result handshake
//   out                  a - b modulo 2^WIDTH
//   overflow, zf, sf     signed overflow, zero, sign flags
module sub64_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CHUNK = ALU_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             overflow,
    output logic             zf,
    output logic             sf
);

    localparam int NSTEP = WIDTH / CHUNK;
    localparam int SW = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [SW-1:0] LAST = SW'(NSTEP - 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q, nb_q, res;
    logic [SW-1:0]    step;
    logic             carry, cout, accept, last;
    logic [CHUNK-1:0] x, y, sum;

    assign x = a_q[32'(step) * CHUNK +: CHUNK];
    assign y = nb_q[32'(step) * CHUNK +: CHUNK];

    sub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .x    (x),
        .y    (y),
        .cin  (carry),
        .sum  (sum),
        .cout (cout)
    );

    assign accept = in_valid && in_ready;
    assign last   = (state == CALC) && (step == LAST);

    // Full result as it will look once the top slice lands this cycle
    always_comb begin
        res = out;
        res[WIDTH-1 -: CHUNK] = sum;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                state_nx = in_valid ? CALC : IDLE;
            end
            CALC: state_nx = last ? DONE : CALC;
            DONE: begin
                out_valid = 1'b1;
                state_nx  = out_ready ? IDLE : DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_q      <= '0;
            nb_q     <= '0;
            out      <= '0;
            step     <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zf       <= 1'b0;
            sf       <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_q   <= a;
                nb_q  <= ~b;
                carry <= 1'b1;
                step  <= '0;
            end else if (state == CALC) begin
                out[32'(step) * CHUNK +: CHUNK] <= sum;
                carry <= cout;
                step  <= step + 1'b1;
                if (last) begin
                    // nb holds ~b, so equal MSBs of a and nb mean a and b differ in sign
                    overflow <= (a_q[WIDTH-1] == nb_q[WIDTH-1]) && (sum[CHUNK-1] != a_q[WIDTH-1]);
                    zf       <= (res == '0);
                    sf       <= sum[CHUNK-1];
                end
            end
        end
    end

endmodule
